// File: rtl/pin_bank.sv
// pin_bank: bank of per-pin channels, each a hi-Z / constant / square-wave
// driver or an edge-counting recorder, behind a word-addressed register bus.
module pin_bank #(
    parameter int          NUM_PINS   = 16,
    parameter int          ADDR_WIDTH = 21,
    parameter int          DATA_WIDTH = 16,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int          CH_STRIDE  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  wr,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    inout  wire  [NUM_PINS-1:0]   pin
);
    localparam int OFF_W = $clog2(CH_STRIDE);
    localparam int CHF_W = ADDR_WIDTH - OFF_W;
    localparam int CH_W  = (NUM_PINS > 1) ? $clog2(NUM_PINS) : 1;
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [CHF_W-1:0]      NP   = CHF_W'(NUM_PINS);

    typedef logic [DATA_WIDTH-1:0] word_t;

    logic                  borrow;
    logic [ADDR_WIDTH-1:0] rel;
    logic [CHF_W-1:0]      ch_full;
    logic [OFF_W-1:0]      off;
    logic [CH_W-1:0]       ch;
    logic [2:0]            reg_sel;
    logic                  hit;
    logic                  lo_off;
    word_t                 rd_val [NUM_PINS];

    // Borrow out of the subtraction means addr is below the bank.
    assign {borrow, rel} = {1'b0, addr} - {1'b0, BASE};
    assign ch_full = rel[ADDR_WIDTH-1:OFF_W];
    assign off     = rel[OFF_W-1:0];
    assign hit     = !borrow && (ch_full < NP);
    assign ch      = CH_W'(ch_full);
    assign lo_off  = ((off >> 3) == '0);
    assign reg_sel = off[2:0];

    for (genvar i = 0; i < NUM_PINS; i++) begin : g_ch
        logic [1:0]      mode_q;
        word_t           period_q;
        word_t           duty_q;
        word_t           phase_q;
        word_t           cnt_q;
        word_t           count_q;
        logic            const_q;
        logic            s1_q;
        logic            s2_q;
        logic            sel;
        logic            restart;
        logic            wrap;
        logic            sq;
        logic            oe;
        logic [DATA_WIDTH:0] nxt;
        word_t           rv;

        assign sel     = wr && hit && lo_off && (ch == CH_W'(i));
        assign restart = sel && ((reg_sel == 3'd0) ||
                                 (reg_sel == 3'd7 && data_in[0]));
        assign nxt     = {1'b0, cnt_q} + 1'b1;
        assign wrap    = (period_q != '0) && (nxt >= {1'b0, period_q});
        assign sq      = (period_q != '0) && (cnt_q < duty_q);
        assign oe      = (mode_q == 2'd1) || (mode_q == 2'd2);
        assign pin[i]  = oe ? ((mode_q == 2'd1) ? const_q : sq) : 1'bz;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                mode_q   <= '0;
                period_q <= '0;
                duty_q   <= '0;
                phase_q  <= '0;
                cnt_q    <= '0;
                count_q  <= '0;
                const_q  <= 1'b0;
                s1_q     <= 1'b0;
                s2_q     <= 1'b0;
            end else begin
                s1_q <= pin[i];
                s2_q <= s1_q;
                if (sel) begin
                    unique case (reg_sel)
                        3'd0:    mode_q   <= data_in[1:0];
                        3'd1:    period_q <= data_in;
                        3'd2:    duty_q   <= data_in;
                        3'd3:    phase_q  <= data_in;
                        3'd4:    const_q  <= data_in[0];
                        default: ;
                    endcase
                end
                if (restart) begin
                    cnt_q   <= (phase_q < period_q) ? phase_q : '0;
                    count_q <= '0;
                end else if (mode_q == 2'd2) begin
                    cnt_q <= (nxt >= {1'b0, period_q}) ? '0 : nxt[DATA_WIDTH-1:0];
                    if (wrap && count_q != '1)
                        count_q <= count_q + 1'b1;
                end else if (mode_q == 2'd3) begin
                    if (s1_q != s2_q && count_q != '1)
                        count_q <= count_q + 1'b1;
                end
            end
        end

        always_comb begin
            rv = '0;
            if (lo_off) begin
                unique case (reg_sel)
                    3'd0:    rv = word_t'(mode_q);
                    3'd1:    rv = period_q;
                    3'd2:    rv = duty_q;
                    3'd3:    rv = phase_q;
                    3'd4:    rv = word_t'(const_q);
                    3'd5:    rv = count_q;
                    3'd6:    rv = word_t'(s2_q);
                    default: rv = '0;
                endcase
            end
        end

        assign rd_val[i] = rv;
    end

    // Registers are sampled before this edge's write lands: read-before-write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
        end else if (rd && hit) begin
            data_out   <= rd_val[ch];
            data_valid <= 1'b1;
        end else begin
            data_out   <= '0;
            data_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pin_bank.sv
// Directed bench for pin_bank: register table plus square, record,
// collision and reset sequences.
module tb_pin_bank;
    logic        clk = 1'b0;
    logic        reset;
    logic [20:0] addr;
    logic [15:0] data_in;
    logic        wr;
    logic        rd;
    logic [15:0] data_out;
    logic        data_valid;
    wire  [15:0] pin;
    logic        ext_en;
    logic        ext_val;

    int total = 0;
    int bad   = 0;

    assign pin[2] = ext_en ? ext_val : 1'bz;

    pin_bank dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .data_in    (data_in),
        .wr         (wr),
        .rd         (rd),
        .data_out   (data_out),
        .data_valid (data_valid),
        .pin        (pin)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        do_wr;
        logic [20:0] a;
        logic [15:0] wd;
        logic [15:0] ed;
        logic        ev;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic do_write(input logic [20:0] a, input logic [15:0] d);
        @(negedge clk);
        addr = a; data_in = d; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic do_read(input logic [20:0] a, output logic [15:0] d,
                           output logic v);
        @(negedge clk);
        addr = a; rd = 1'b1;
        @(posedge clk);
        #1;
        d = data_out; v = data_valid;
        rd = 1'b0;
    endtask

    function automatic logic [20:0] ra(input int c, input int o);
        return 21'(c * 32 + o);
    endfunction

    initial begin
        vec_t        vt [17];
        logic [15:0] d;
        logic        v;

        vt[0]  = '{1'b0, ra(0, 0),   16'h0000, 16'h0000, 1'b1};
        vt[1]  = '{1'b1, ra(4, 1),   16'h1234, 16'h1234, 1'b1};
        vt[2]  = '{1'b1, ra(4, 2),   16'hBEEF, 16'hBEEF, 1'b1};
        vt[3]  = '{1'b1, ra(4, 3),   16'h0007, 16'h0007, 1'b1};
        vt[4]  = '{1'b1, ra(4, 4),   16'hFFFE, 16'h0000, 1'b1};
        vt[5]  = '{1'b1, ra(4, 4),   16'h0003, 16'h0001, 1'b1};
        vt[6]  = '{1'b1, ra(4, 0),   16'h0007, 16'h0003, 1'b1};
        vt[7]  = '{1'b1, ra(4, 7),   16'h0001, 16'h0000, 1'b1};
        vt[8]  = '{1'b1, ra(4, 5),   16'h0055, 16'h0000, 1'b1};
        vt[9]  = '{1'b1, ra(5, 9),   16'h00AA, 16'h0000, 1'b1};
        vt[10] = '{1'b0, 21'd512,    16'h0000, 16'h0000, 1'b0};
        vt[11] = '{1'b1, ra(15, 1),  16'h55AA, 16'h55AA, 1'b1};
        vt[12] = '{1'b1, ra(5, 1),   16'h0009, 16'h0009, 1'b1};
        vt[13] = '{1'b0, ra(4, 1),   16'h0000, 16'h1234, 1'b1};
        vt[14] = '{1'b1, 21'd513,    16'h1111, 16'h0000, 1'b0};
        vt[15] = '{1'b0, ra(15, 1),  16'h0000, 16'h55AA, 1'b1};
        vt[16] = '{1'b0, ra(0, 1),   16'h0000, 16'h0000, 1'b1};

        reset = 1'b1; wr = 1'b0; rd = 1'b0;
        addr = '0; data_in = '0;
        ext_en = 1'b0; ext_val = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_dout", 32'(data_out), 0);
        chk("rst_dv", 32'(data_valid), 0);
        chk("rst_pins_z", 32'(pin === 16'hzzzz), 1);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            if (vt[i].do_wr) do_write(vt[i].a, vt[i].wd);
            do_read(vt[i].a, d, v);
            chk($sformatf("vec%0d_data", i), 32'(d), 32'(vt[i].ed));
            chk($sformatf("vec%0d_valid", i), 32'(v), 32'(vt[i].ev));
        end

        // Constant drive on ch3, everything else released.
        do_write(ra(3, 4), 16'h0001);
        do_write(ra(3, 0), 16'h0001);
        @(negedge clk);
        chk("const_pin3", 32'(pin[3]), 1);
        chk("const_others_z",
            32'(pin === 16'bzzzz_zzzz_zzzz_1zzz), 1);

        // Square ch0: period 4, duty 1.
        do_write(ra(0, 1), 16'd4);
        do_write(ra(0, 2), 16'd1);
        do_write(ra(0, 0), 16'd2);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("sq0_k%0d", k), 32'(pin[0]),
                32'((k % 4) == 0));
            @(negedge clk);
        end
        repeat (31) @(negedge clk);
        do_read(ra(0, 5), d, v);
        chk("sq0_count", 32'(d), 10);

        // Phase preload on ch7: cnt starts at 3.
        do_write(ra(7, 1), 16'd4);
        do_write(ra(7, 2), 16'd2);
        do_write(ra(7, 3), 16'd3);
        do_write(ra(7, 0), 16'd2);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("ph7_k%0d", k), 32'(pin[7]),
                32'(((3 + k) % 4) < 2));
            @(negedge clk);
        end

        // ch1: duty above period is constant high, then period 0 is low.
        do_write(ra(1, 1), 16'd5);
        do_write(ra(1, 2), 16'd7);
        do_write(ra(1, 0), 16'd2);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("hi1_k%0d", k), 32'(pin[1]), 1);
            @(negedge clk);
        end
        do_write(ra(1, 1), 16'd0);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("lo1_k%0d", k), 32'(pin[1]), 0);
            @(negedge clk);
        end
        repeat (10) @(negedge clk);
        do_read(ra(1, 5), d, v);
        chk("p0_count_frozen", 32'(d), 2);

        // Record on ch2: six external toggles ending high.
        ext_en = 1'b1; ext_val = 1'b1;
        repeat (4) @(negedge clk);
        do_write(ra(2, 0), 16'd3);
        for (int k = 0; k < 6; k++) begin
            ext_val = ~ext_val;
            repeat (10) @(negedge clk);
            chk($sformatf("rec2_pin_k%0d", k), 32'(pin[2]), 32'(ext_val));
        end
        do_read(ra(2, 5), d, v);
        chk("rec2_count", 32'(d), 6);
        do_read(ra(2, 6), d, v);
        chk("rec2_last", 32'(d), 1);
        ext_en = 1'b0;

        // Same-cycle write and read of one register returns the old value.
        do_write(ra(6, 1), 16'd10);
        @(negedge clk);
        addr = ra(6, 1); data_in = 16'd20; wr = 1'b1; rd = 1'b1;
        @(posedge clk);
        #1;
        chk("rw_old", 32'(data_out), 10);
        chk("rw_valid", 32'(data_valid), 1);
        @(negedge clk);
        wr = 1'b0; rd = 1'b0;
        do_read(ra(6, 1), d, v);
        chk("rw_new", 32'(d), 20);

        // Reset with square running and a read in flight.
        @(negedge clk);
        addr = ra(0, 1); rd = 1'b1;
        @(posedge clk);
        #1;
        chk("inflight_dv", 32'(data_valid), 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_dv", 32'(data_valid), 0);
        chk("rst_mid_dout", 32'(data_out), 0);
        chk("rst_mid_pins_z", 32'(pin === 16'hzzzz), 1);
        rd = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        do_read(ra(0, 0), d, v);
        chk("post_mode0", 32'(d), 0);
        chk("post_valid", 32'(v), 1);
        do_read(ra(0, 1), d, v);
        chk("post_period0", 32'(d), 0);
        do_read(ra(0, 5), d, v);
        chk("post_count0", 32'(d), 0);
        do_read(ra(3, 4), d, v);
        chk("post_const3", 32'(d), 0);
        do_read(ra(6, 1), d, v);
        chk("post_period6", 32'(d), 0);
        chk("post_pins_z", 32'(pin === 16'hzzzz), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
